// File: rtl/boid_pkg.sv
// ============================================================================
// boid_pkg : shared types, FSM encoding and default tuning constants
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package boid_pkg;

   typedef logic signed [31:0] fix16_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DIV   = 3'd1,
      STEER = 3'd2,
      LIMIT = 3'd3,
      MOVE  = 3'd4
   } state_t;

   localparam int     CENTER_SHIFT_DEF = 10;
   localparam int     MATCH_SHIFT_DEF  = 3;
   localparam int     AVOID_SHIFT_DEF  = 4;
   localparam fix16_t TURN_DEF         = 32'sd13107;
   localparam fix16_t MARGIN_L_DEF     = 32'sd100 <<< 16;
   localparam fix16_t MARGIN_R_DEF     = 32'sd540 <<< 16;
   localparam fix16_t MARGIN_T_DEF     = 32'sd100 <<< 16;
   localparam fix16_t MARGIN_B_DEF     = 32'sd380 <<< 16;
   localparam fix16_t SCREEN_W_DEF     = 32'sd640 <<< 16;
   localparam fix16_t SCREEN_H_DEF     = 32'sd480 <<< 16;
   localparam fix16_t MAX_SPEED_DEF    = 32'sd6 <<< 16;
   localparam fix16_t MIN_SPEED_DEF    = 32'sd3 <<< 16;
   localparam int     LIMIT_ITERS_DEF  = 16;

   // Magnitude as unsigned; the most negative value maps to 2^31 exactly.
   function automatic logic [31:0] mag(input fix16_t v);
      return v[31] ? 32'(-v) : 32'(v);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : unsigned 32/6 restoring divider, 32 cycles per quotient
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module seq_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [5:0]  divisor,
   output logic [31:0] quotient,
   output logic        done
);

   logic [5:0]  rem;
   logic [5:0]  div_r;
   logic [4:0]  cnt;
   logic        running;

   logic [31:0] q_src;
   logic [5:0]  rem_src;
   logic [5:0]  d_src;
   logic [6:0]  trial;
   logic [5:0]  rem_nxt;
   logic [31:0] q_nxt;

   // The start cycle performs the first step straight from the inputs,
   // so 32 steps complete exactly 32 edges after start.
   always_comb begin
      q_src   = start ? dividend : quotient;
      rem_src = start ? 6'd0     : rem;
      d_src   = start ? divisor  : div_r;
      trial   = {rem_src, q_src[31]};
      rem_nxt = trial[5:0];
      q_nxt   = {q_src[30:0], 1'b0};
      if (trial >= {1'b0, d_src}) begin
         rem_nxt = 6'(trial - {1'b0, d_src});
         q_nxt   = {q_src[30:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem      <= '0;
         div_r    <= '0;
         cnt      <= '0;
         running  <= 1'b0;
         quotient <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            quotient <= q_nxt;
            rem      <= rem_nxt;
            div_r    <= divisor;
            cnt      <= 5'd1;
            running  <= 1'b1;
         end else if (running) begin
            quotient <= q_nxt;
            rem      <= rem_nxt;
            cnt      <= cnt + 5'd1;
            if (cnt == 5'd31) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/boid_vel_update.sv
// ============================================================================
// boid_vel_update : flocking rules, speed limit and move for one boid
// Rev 1.0 : initial release; BOID_WRAP_EN selects screen wrap over edge steering
// ============================================================================
`default_nettype none

module boid_vel_update
   import boid_pkg::*;
#(
   parameter int     CENTER_SHIFT = CENTER_SHIFT_DEF,
   parameter int     MATCH_SHIFT  = MATCH_SHIFT_DEF,
   parameter int     AVOID_SHIFT  = AVOID_SHIFT_DEF,
   parameter fix16_t TURN         = TURN_DEF,
   parameter fix16_t MARGIN_L     = MARGIN_L_DEF,
   parameter fix16_t MARGIN_R     = MARGIN_R_DEF,
   parameter fix16_t MARGIN_T     = MARGIN_T_DEF,
   parameter fix16_t MARGIN_B     = MARGIN_B_DEF,
   parameter fix16_t SCREEN_W     = SCREEN_W_DEF,
   parameter fix16_t SCREEN_H     = SCREEN_H_DEF,
   parameter fix16_t MAX_SPEED    = MAX_SPEED_DEF,
   parameter fix16_t MIN_SPEED    = MIN_SPEED_DEF,
   parameter int     LIMIT_ITERS  = LIMIT_ITERS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic [31:0] vx,
   input  logic [31:0] vy,
   input  logic [31:0] x_avg,
   input  logic [31:0] y_avg,
   input  logic [31:0] vx_avg,
   input  logic [31:0] vy_avg,
   input  logic [31:0] x_close,
   input  logic [31:0] y_close,
   input  logic [5:0]  boid_ctr,
   output logic        busy,
   output logic        done,
   output logic [31:0] x_out,
   output logic [31:0] y_out,
   output logic [31:0] vx_out,
   output logic [31:0] vy_out
);

`ifdef BOID_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   state_t      state, next;

   fix16_t      x_r, y_r, vx_r, vy_r, xc_r, yc_r;
   fix16_t      sum_r [0:3];
   fix16_t      avg_r [0:3];
   logic [5:0]  n_r;
   logic [1:0]  div_idx;
   logic [5:0]  iter;

   logic        div_start;
   logic [31:0] div_dividend;
   logic [5:0]  div_divisor;
   logic [31:0] div_q;
   logic        div_done;

   fix16_t      vx_st, vy_st;
   logic [31:0] ax, ay, mx, mn;
   logic [32:0] speed;
   logic        too_fast, too_slow, limit_exit;
   fix16_t      x_sum, y_sum, x_nxt, y_nxt;

   seq_divider u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .quotient (div_q),
      .done     (div_done)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next;
   end

   // The first division launches from IDLE on the raw inputs; each later one
   // launches in the done cycle of its predecessor, keeping DIV at 128 cycles.
   always_comb begin
      next         = state;
      div_start    = 1'b0;
      div_dividend = mag(fix16_t'(x_avg));
      div_divisor  = boid_ctr;
      case (state)
         IDLE: begin
            if (start) begin
               next      = (boid_ctr != 6'd0) ? DIV : STEER;
               div_start = (boid_ctr != 6'd0);
            end
         end
         DIV: begin
            div_dividend = mag(sum_r[2'(div_idx + 2'd1)]);
            div_divisor  = n_r;
            if (div_done) begin
               if (div_idx == 2'd3) next = STEER;
               else                 div_start = 1'b1;
            end
         end
         STEER:   next = LIMIT;
         LIMIT:   if (limit_exit) next = MOVE;
         MOVE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      vx_st = vx_r;
      vy_st = vy_r;
      if (n_r != 6'd0) begin
         vx_st = vx_st + ((avg_r[0] - x_r) >>> CENTER_SHIFT)
                       + ((avg_r[2] - vx_r) >>> MATCH_SHIFT);
         vy_st = vy_st + ((avg_r[1] - y_r) >>> CENTER_SHIFT)
                       + ((avg_r[3] - vy_r) >>> MATCH_SHIFT);
      end
      vx_st = vx_st + (xc_r >>> AVOID_SHIFT);
      vy_st = vy_st + (yc_r >>> AVOID_SHIFT);
      if (!WRAP_EN) begin
         if (x_r < MARGIN_L) vx_st = vx_st + TURN;
         if (x_r > MARGIN_R) vx_st = vx_st - TURN;
         if (y_r < MARGIN_T) vy_st = vy_st + TURN;
         if (y_r > MARGIN_B) vy_st = vy_st - TURN;
      end
   end

   // Alpha-max-beta-min speed estimate: max + min/2.
   always_comb begin
      ax         = mag(vx_r);
      ay         = mag(vy_r);
      mx         = (ax > ay) ? ax : ay;
      mn         = (ax > ay) ? ay : ax;
      speed      = {1'b0, mx} + {1'b0, mn >> 1};
      too_fast   = (speed > {1'b0, MAX_SPEED});
      too_slow   = (speed < {1'b0, MIN_SPEED});
      limit_exit = (!too_fast && !too_slow) || (iter == 6'(LIMIT_ITERS))
                || (vx_r == 32'sd0 && vy_r == 32'sd0);
   end

   always_comb begin
      x_sum = x_r + vx_r;
      y_sum = y_r + vy_r;
      x_nxt = x_sum;
      y_nxt = y_sum;
      if (WRAP_EN) begin
         if (x_sum < 32'sd0)         x_nxt = x_sum + SCREEN_W;
         else if (x_sum >= SCREEN_W) x_nxt = x_sum - SCREEN_W;
         if (y_sum < 32'sd0)         y_nxt = y_sum + SCREEN_H;
         else if (y_sum >= SCREEN_H) y_nxt = y_sum - SCREEN_H;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_r     <= '0;
         y_r     <= '0;
         vx_r    <= '0;
         vy_r    <= '0;
         xc_r    <= '0;
         yc_r    <= '0;
         n_r     <= '0;
         div_idx <= '0;
         iter    <= '0;
         for (int i = 0; i < 4; i++) begin
            sum_r[i] <= '0;
            avg_r[i] <= '0;
         end
         done    <= 1'b0;
         x_out   <= '0;
         y_out   <= '0;
         vx_out  <= '0;
         vy_out  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  x_r      <= x;
                  y_r      <= y;
                  vx_r     <= vx;
                  vy_r     <= vy;
                  xc_r     <= x_close;
                  yc_r     <= y_close;
                  sum_r[0] <= x_avg;
                  sum_r[1] <= y_avg;
                  sum_r[2] <= vx_avg;
                  sum_r[3] <= vy_avg;
                  n_r      <= boid_ctr;
                  div_idx  <= '0;
                  iter     <= '0;
               end
            end
            DIV: begin
               if (div_done) begin
                  avg_r[div_idx] <= sum_r[div_idx][31] ? fix16_t'(-div_q)
                                                       : fix16_t'(div_q);
                  div_idx        <= div_idx + 2'd1;
               end
            end
            STEER: begin
               vx_r <= vx_st;
               vy_r <= vy_st;
            end
            LIMIT: begin
               if (!limit_exit) begin
                  if (too_fast) begin
                     vx_r <= vx_r - (vx_r >>> 3);
                     vy_r <= vy_r - (vy_r >>> 3);
                  end else begin
                     vx_r <= vx_r + (vx_r >>> 3);
                     vy_r <= vy_r + (vy_r >>> 3);
                  end
                  iter <= iter + 6'd1;
               end
            end
            MOVE: begin
               x_out  <= x_nxt;
               y_out  <= y_nxt;
               vx_out <= vx_r;
               vy_out <= vy_r;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/boid_vel_update.md
# boid_vel_update

Per-boid update stage directly downstream of the neighbour-scan accumulator (`xy_sep_chk`). After the scan over all other boids finishes, it takes the accumulated position/velocity sums, the separation offsets and the neighbour count. It then applies cohesion, alignment, separation, edge steering and the speed limit, and produces the boid's next position and velocity for write-back to boid memory. All values are signed 16.16 fixed point (1.0 = 32'h0001_0000).

## Interface
- CENTER_SHIFT, 10: cohesion gain as right shift
- MATCH_SHIFT, 3: alignment gain as right shift
- AVOID_SHIFT, 4: separation gain as right shift
- TURN, 32'd13107: edge turn factor (~0.2)
- MARGIN_L / MARGIN_R / MARGIN_T / MARGIN_B, 100<<16 / 540<<16 / 100<<16 / 380<<16: steering margins
- SCREEN_W / SCREEN_H, 640<<16 / 480<<16: wrap extents (BOID_WRAP_EN only)
- MAX_SPEED / MIN_SPEED, 6<<16 / 3<<16: speed bounds
- LIMIT_ITERS, 16: maximum speed-adjust iterations

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- x, y, vx, vy  in  32 each  current boid state
- x_avg, y_avg, vx_avg, vy_avg  in  32 each  neighbour sums (signed)
- x_close, y_close  in  32 each  separation sums
- boid_ctr  in  6  neighbour count n
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when outputs are valid
- x_out, y_out, vx_out, vy_out  out  32 each  registered results, held until the next done

## Operation
- FSM states: IDLE, DIV, STEER, LIMIT, MOVE.
- IDLE: when start=1, latch all inputs. Go to DIV if n>0, otherwise go to STEER.
- DIV: four sequential signed divisions of each sum by n, in the order x, y, vx, vy, 32 cycles each. Each division divides the magnitude and reapplies the sign, so quotients truncate toward zero.
- STEER (1 cycle), per axis, with wrapping 32-bit arithmetic and arithmetic shifts:
  - if n>0: v += (avg−pos)>>>CENTER_SHIFT + (vavg−v)>>>MATCH_SHIFT
  - v += close>>>AVOID_SHIFT
  - if x<MARGIN_L: vx += TURN; if x>MARGIN_R: vx −= TURN; same for y with MARGIN_T/MARGIN_B
- LIMIT: each cycle computes speed = max(|vx|,|vy|) + (min(|vx|,|vy|)>>1).
  - Exit to MOVE if MIN_SPEED ≤ speed ≤ MAX_SPEED, if LIMIT_ITERS adjustments are done, or if vx=vy=0.
  - If speed > MAX_SPEED: v −= v>>>3 on both axes.
  - If speed < MIN_SPEED: v += v>>>3 on both axes.
- MOVE: pos_out = pos + v; register all four outputs and done; return to IDLE.
- start while busy is ignored, with no queuing.

## Timing
- Reset: state=IDLE; busy, done and all outputs = 0.
- Latency, with start sampled at edge E and k = number of LIMIT adjustments (0..16):
  - n>0: done is high after edge E+131+k.
  - n=0: done is high after edge E+3+k.
- done is high for exactly one cycle; outputs change only in that same cycle.
- busy rises after edge E and falls in the done cycle, so a new start is accepted in the cycle after done.
- Reset asserted in any state aborts the operation: IDLE, outputs cleared, no done pulse.

## Configuration
- BOID_WRAP_EN defined:
  - Edge TURN steering is removed.
  - After MOVE, a position <0 gets +SCREEN_W/H added; a position ≥SCREEN_W/H gets SCREEN_W/H subtracted.
  - Latency is unchanged.
- BOID_WRAP_EN undefined: margin steering as above, and positions are not wrapped.

## Structure
- boid_pkg holds:
  - fix16_t typedef (logic signed [31:0])
  - FSM state enum
  - default gain, margin and speed constants
- Sub-module seq_divider: unsigned 32/6 restoring divider.
  - Ports: start, dividend, divisor, quotient, done.
  - Fixed 32-cycle latency; the divisor is never 0 because DIV is skipped when n=0.

## Test plan
- No neighbours, in range: n=0, x=y=140<<16, vx=vy=3<<16, sums=0 -> done after E+3; vx_out=vy_out=196608, x_out=y_out=143<<16.
- Cohesion and alignment: n=2, x_avg=290<<16, y_avg=280<<16, vx_avg=vy_avg=0, x=y=140<<16, vx=vy=3<<16 -> done after E+131; vx_out=172352, vy_out=172032, x_out=9347392.
- Overspeed: n=0, vx=vy=8<<16 -> k ≥ 1; final speed ≤ MAX_SPEED or k=16; vx_out=vy_out.
- Edge steering: x=50<<16, vx=vy=3<<16, n=0 -> vx_out=196608+13107. With BOID_WRAP_EN: x=639<<16, vx=3<<16 -> x_out=2<<16.
- Signed division: n=3, x_avg=−(10<<16), other sums 0, x=0 -> internal x average = −218453 (truncated toward zero); vx_out matches the STEER formula.
- Control: reset asserted mid-DIV -> busy=0, done never pulses, outputs 0. A start pulse during busy -> ignored, exactly one done pulse.
